// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the round-robin shared ALU: opcodes, flag bit positions
// and the combinational ALU evaluation used by the arbiter top.
package alu_share_arbiter_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  flags;
        logic        err;
    } alu_out_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return op inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT};
    endfunction

    function automatic alu_out_t alu_eval(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
        alu_out_t    o;
        logic [32:0] wide;
        o    = '0;
        wide = '0;
        case (op)
            ALU_ADD: begin
                wide            = {1'b0, a} + {1'b0, b};
                o.result        = wide[31:0];
                o.flags[FLAG_C] = wide[32];
                o.flags[FLAG_V] = (a[31] == b[31]) && (o.result[31] != a[31]);
            end
            ALU_SUB: begin
                // Carry is the raw borrow out of the 33-bit subtraction.
                wide            = {1'b0, a} - {1'b0, b};
                o.result        = wide[31:0];
                o.flags[FLAG_C] = wide[32];
                o.flags[FLAG_V] = (a[31] ^ b[31]) & (a[31] ^ o.result[31]);
            end
            ALU_AND: o.result = a & b;
            ALU_OR:  o.result = a | b;
            ALU_SLT: o.result = {31'b0, $signed(a) < $signed(b)};
            default: o.result = '0;
        endcase
        o.err           = !is_legal_op(op);
        o.flags[FLAG_Z] = (o.result == 32'd0);
        o.flags[FLAG_N] = o.result[31];
        return o;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Round-robin priority picker: first asserted request at or after ptr, wrapping.
// Produces a one-hot grant, its encoded index and an any-request indication.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    int pos;

    // NOTE: every output gets a default before the scan so no path leaves one unassigned (no latch).
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[pos]) begin
                grant[pos] = 1'b1;
                idx        = ID_W'(pos);
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// One ALU shared by NUM_REQ valid/ready requesters under round-robin arbitration,
// with a single registered, id/tag-annotated response stage (1-cycle latency).
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int TAG_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*32-1:0]    req_a,
    input  logic [NUM_REQ*32-1:0]    req_b,
    input  logic [NUM_REQ*3-1:0]     req_op,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_result,
    output logic [3:0]               rsp_flags,
    output logic [ID_W-1:0]          rsp_id,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic                     rsp_err,
    output logic                     busy
);

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    ptr_next;
    logic [ID_W-1:0]    win_idx;
    logic [NUM_REQ-1:0] win_grant;
    logic               win_any;
    logic               out_free;
    logic               fire;
    logic [31:0]        sel_a;
    logic [31:0]        sel_b;
    logic [2:0]         sel_op;
    logic [TAG_W-1:0]   sel_tag;
    alu_out_t           alu_q;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W)
    ) u_arb (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .grant(win_grant),
        .idx  (win_idx),
        .any  (win_any)
    );

    // Ready depends only on req_valid, the pointer and the output stage, never on req_ready itself.
    assign out_free  = ~rsp_valid | rsp_ready;
    assign req_ready = (rst && out_free) ? win_grant : '0;
    assign fire      = win_any && |(req_valid & req_ready);

    assign sel_a   = req_a[32*win_idx +: 32];
    assign sel_b   = req_b[32*win_idx +: 32];
    assign sel_op  = req_op[3*win_idx +: 3];
    assign sel_tag = req_tag[TAG_W*win_idx +: TAG_W];
    assign alu_q   = alu_eval(sel_a, sel_b, sel_op);

    assign ptr_next = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
    assign busy     = rsp_valid | (|req_valid);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_id     <= '0;
            rsp_tag    <= '0;
            rsp_err    <= 1'b0;
            rr_ptr     <= '0;
        end else if (fire) begin
            rsp_valid  <= 1'b1;
            rsp_result <= alu_q.result;
            rsp_flags  <= alu_q.flags;
            rsp_id     <= win_idx;
            rsp_tag    <= sel_tag;
            rsp_err    <= alu_q.err;
            rr_ptr     <= ptr_next;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
